// File: rtl/wlmr_pkg.sv
// Shared sizing helpers for the word-level Montgomery reducer.
package wlmr_pkg;

  // Number of word-reduction steps K = ceil(a/b).
  function automatic int clog_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Per-stage datapath width: one guard bit above the 2*LOGQ product.
  function automatic int stage_w(input int logq);
    return 2 * logq + 1;
  endfunction

endpackage

// File: rtl/wlmr_step.sv
// One combinational Montgomery word step: T' = (T + m*q) / 2^WORD_SIZE, using q = qH*2^W + 1.
module wlmr_step
  import wlmr_pkg::*;
#(
  parameter int LOGQ      = 32,
  parameter int WORD_SIZE = 16,
  parameter int SW        = stage_w(LOGQ)
) (
  input  logic [SW-1:0]             t,
  input  logic [LOGQ-WORD_SIZE-1:0] qh,
  output logic [SW-1:0]             t_next
);

  logic [WORD_SIZE-1:0] t_lo;
  logic [WORD_SIZE-1:0] m;
  logic [LOGQ-1:0]      mq;

  assign t_lo = t[WORD_SIZE-1:0];
  assign m    = -t_lo;
  assign mq   = {{(LOGQ-WORD_SIZE){1'b0}}, m} * {{WORD_SIZE{1'b0}}, qh};

  // The low word of T + m*q is always zero; its carry out is exactly (t_lo != 0).
  assign t_next = (t >> WORD_SIZE)
                + {{(SW-LOGQ){1'b0}}, mq}
                + {{(SW-1){1'b0}}, (t_lo != '0)};

endmodule

// File: rtl/wlmr_reduce.sv
// Pipelined word-level Montgomery reduction, out = T*2^(-K*W) mod q; latency K+1 (K with WLMR_LAZY_OUT_EN, result < 2q).
// stall freezes every register including valids; no ready path, one operand per cycle otherwise.
module wlmr_reduce
  import wlmr_pkg::*;
#(
  parameter int              LOGQ      = 32,
  parameter longint unsigned Q_VALUE   = 0,
  parameter int              WORD_SIZE = 16,
  parameter int              TAG_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LOGQ-WORD_SIZE-1:0] qH,
  input  logic                      stall,
  input  logic                      in_valid,
  input  logic [2*LOGQ-1:0]         in_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  output logic [LOGQ-1:0]           out_data,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int              K  = clog_div(LOGQ, WORD_SIZE);
  localparam int              SW = stage_w(LOGQ);
  localparam logic [LOGQ-1:0] QV = LOGQ'(Q_VALUE);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [SW-1:0]    t;
  } stage_t;

  logic [LOGQ-WORD_SIZE-1:0] qh_eff;
  assign qh_eff = (Q_VALUE != 0) ? QV[LOGQ-1:WORD_SIZE] : qH;

  for (genvar k = 0; k < K; k++) begin : g_stage
    logic [SW-1:0]    step_in;
    logic [SW-1:0]    step_out;
    logic             vld_in;
    logic [TAG_W-1:0] tag_in;
    stage_t           st;

    if (k == 0) begin : g_first
      assign step_in = {1'b0, in_data};
      assign vld_in  = in_valid;
      assign tag_in  = in_tag;
    end else begin : g_next
      assign step_in = g_stage[k-1].st.t;
      assign vld_in  = g_stage[k-1].st.valid;
      assign tag_in  = g_stage[k-1].st.tag;
    end

    wlmr_step #(
      .LOGQ      (LOGQ),
      .WORD_SIZE (WORD_SIZE),
      .SW        (SW)
    ) u_step (
      .t      (step_in),
      .qh     (qh_eff),
      .t_next (step_out)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        st <= '0;
      end else if (!stall) begin
        st.valid <= vld_in;
        st.tag   <= tag_in;
        st.t     <= step_out;
      end
    end
  end

  stage_t last;
  assign last = g_stage[K-1].st;

`ifdef WLMR_LAZY_OUT_EN
  logic unused_hi;
  assign unused_hi = ^last.t[SW-1:LOGQ];

  assign out_valid = last.valid;
  assign out_data  = last.valid ? last.t[LOGQ-1:0] : '0;
  assign out_tag   = last.tag;
`else
  logic [LOGQ-1:0] q;
  logic [SW-1:0]   d;
  logic [LOGQ-1:0] red;
  logic            unused_hi;

  // T_K < 2q, so a single conditional subtract lands in [0,q).
  assign q         = {qh_eff, {{(WORD_SIZE-1){1'b0}}, 1'b1}};
  assign d         = last.t - {{(LOGQ+1){1'b0}}, q};
  assign red       = d[SW-1] ? last.t[LOGQ-1:0] : d[LOGQ-1:0];
  assign unused_hi = ^d[SW-2:LOGQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= last.valid;
      out_data  <= last.valid ? red : '0;
      out_tag   <= last.tag;
    end
  end
`endif

endmodule

// File: tb/tb_wlmr_reduce.sv
// Scoreboard bench for wlmr_reduce with q = 12289 (qH = 0x30, W = 8, K = 2).
module tb_wlmr_reduce;

  localparam int LOGQ  = 14;
  localparam int WS    = 8;
  localparam int TAG_W = 8;
  localparam int Q     = 12289;
  // 2^16 mod q = 4091, and 4091 * 2304 = 767*q + 1.
  localparam longint RINV = 2304;
`ifdef WLMR_LAZY_OUT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [LOGQ-WS-1:0]   qH;
  logic                 stall;
  logic                 in_valid;
  logic [2*LOGQ-1:0]    in_data;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic [LOGQ-1:0]      out_data;
  logic [TAG_W-1:0]     out_tag;

  wlmr_reduce #(
    .LOGQ      (LOGQ),
    .Q_VALUE   (0),
    .WORD_SIZE (WS),
    .TAG_W     (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .qH        (qH),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned data;
    logic [7:0]  tag;
    int unsigned issue;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned ns_cnt = 0;

  int unsigned dv_t[7] = '{65536, 196608, 0, 12289, 131072000, 1, 151019520};
  int unsigned dv_e[7] = '{1,     3,      0, 0,     2000,      2304, 9985};

  // Counts clock edges on which the pipeline actually advances.
  always @(posedge clk) if (!stall && !rst) ns_cnt <= ns_cnt + 1;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: inputs change just after posedge, so values seen here were sampled at the next edge.
  logic        last_stall = 1'b0;
  logic        last_rst   = 1'b1;
  logic        pv;
  logic [13:0] pd;
  logic [7:0]  pt;
  exp_t        e;

  always @(negedge clk) begin
    if (last_rst) begin
      sb.delete();
      chk("reset_out_valid", out_valid == 1'b0, out_valid, 0);
      chk("reset_out_data", out_data == '0, out_data, 0);
      chk("reset_out_tag", out_tag == '0, out_tag, 0);
    end else if (last_stall) begin
      chk("stall_hold_valid", out_valid == pv, out_valid, pv);
      chk("stall_hold_data", out_data == pd, out_data, pd);
      chk("stall_hold_tag", out_tag == pt, out_tag, pt);
    end else if (out_valid) begin
      chk("output_expected", sb.size() != 0, out_data, -1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
`ifdef WLMR_LAZY_OUT_EN
        chk("lazy_data", (int'(out_data) % Q == e.data) && (int'(out_data) < 2*Q), out_data, e.data);
`else
        chk("data", int'(out_data) == e.data, out_data, e.data);
`endif
        chk("tag", out_tag == e.tag, out_tag, e.tag);
        chk("latency", ns_cnt - e.issue == LAT, ns_cnt - e.issue, LAT);
      end
    end else begin
      chk("idle_data_zero", out_data == '0, out_data, 0);
    end
    pv = out_valid;
    pd = out_data;
    pt = out_tag;
    last_stall = stall;
    last_rst   = rst;
  end

  task automatic send(input int unsigned t, input logic [7:0] tag, input int unsigned ev);
    @(posedge clk);
    #1;
    stall    = 1'b0;
    in_valid = 1'b1;
    in_data  = 28'(t);
    in_tag   = tag;
    sb.push_back('{data: ev, tag: tag, issue: ns_cnt});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      stall    = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic stall_cycle();
    @(posedge clk);
    #1;
    stall    = 1'b1;
    in_valid = 1'b1;
    in_data  = 28'd4242;
    in_tag   = 8'hEE;
  endtask

  initial begin
    int unsigned t;
    rst      = 1'b1;
    stall    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_tag   = '0;
    qH       = 6'h30;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 7; i++) send(dv_t[i], 8'(8'h11 + i), dv_e[i]);
    idle(5);

    for (int i = 0; i < 1000; i++) begin
      if (i == 500) repeat (4) stall_cycle();
      t = $urandom_range(Q*Q-1, 0);
      send(t, 8'(i), int'((longint'(t) * RINV) % Q));
    end
    idle(6);

    // Reset with operands in flight: none of them may surface afterwards.
    send(65536, 8'hA1, 1);
    send(196608, 8'hA2, 3);
    send(131072000, 8'hA3, 2000);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 28'd65536;
    in_tag   = 8'hBB;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(6);

    send(65536, 8'hC1, 1);
    send(12289, 8'hC2, 0);
    send(151019520, 8'hC3, 9985);
    idle(1);

    for (int c = 0; c < 50 && sb.size() != 0; c++) @(posedge clk);
    chk("drain_empty", sb.size() == 0, sb.size(), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wlmr_reduce.md
Name: wlmr_reduce

Overview:
- Pipelined word-level Montgomery reduction for moduli of the form q = qH*2^WORD_SIZE + 1.
- Sits between the integer multiplier and the modular adder/subtractor in the butterfly.
- Accepts a 2*LOGQ-bit product T and produces T*2^(-K*WORD_SIZE) mod q in [0,q), where K = ceil(LOGQ/WORD_SIZE).
- Results are handed directly to the modadd/modsub stage.

Parameters:
- LOGQ, 32, modulus bit width.
- Q_VALUE, 0, constant modulus; 0 selects the runtime qH port, nonzero uses Q_VALUE[LOGQ-1:WORD_SIZE] as qH.
- WORD_SIZE, 16, reduction word width; q[WORD_SIZE-1:0] == 1.
- TAG_W, 8, width of the sideband tag carried alongside each operand.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- qH  in  LOGQ-WORD_SIZE  high part of q; quasi-static, ignored when Q_VALUE != 0.
- stall  in  1  global hold; 1 freezes all pipeline registers.
- in_valid  in  1  in_data/in_tag valid this cycle.
- in_data  in  2*LOGQ  product T; T < q^2 required.
- in_tag  in  TAG_W  opaque sideband (e.g. address), delayed with the data.
- out_valid  out  1  out_data/out_tag valid.
- out_data  out  LOGQ  reduced result, 0 <= out_data < q.
- out_tag  out  TAG_W  in_tag of the same operand.

Behaviour:
- Reset: synchronous, active-high, on clk. Clears every stage valid bit. out_valid=0, out_data=0, out_tag=0 the cycle after rst is sampled high. Data registers may also clear.
- Reset mid-operation: all in-flight operands are discarded and never appear at the output. in_valid is ignored while rst=1.
- Per reduction step (K steps, one register stage each):
  - t_lo = T[WORD_SIZE-1:0].
  - m = (2^WORD_SIZE - t_lo) mod 2^WORD_SIZE.
  - T' = (T >> WORD_SIZE) + m*qH + (t_lo != 0).
  - This equals (T + m*q)/2^WORD_SIZE exactly; no multiplier by q is needed.
- Internal width: 2*LOGQ+1 bits per stage. Synthesis may trim; the RTL must not truncate below this bound.
- Final stage: d = T_K - q. If d >= 0 (sign bit clear), output d[LOGQ-1:0]; otherwise output T_K[LOGQ-1:0]. This stage is registered.
- Latency: K+1 clk cycles from an accepted input to out_valid, with stall=0. Fully pipelined, one operand per cycle.
- Valid rule: an input is accepted iff in_valid=1 and stall=0.
- stall=1: no register changes, including valid bits. Outputs hold their values; out_valid is held, so a downstream stage that also stalls sees no duplicates.
- Bubbles propagate as valid=0. Data registers in invalid stages are don't-care, but out_data must be 0 whenever out_valid=0 (aids waveform diffing).
- qH change: only permitted while the pipe is empty. Behaviour otherwise is undefined.

Optional Feature:
- Macro: WLMR_LAZY_OUT_EN.
- Defined: the final subtract stage is removed. Latency is K. out_data = T_K[LOGQ-1:0] in [0,2q) (lazy reduction); the consumer must tolerate inputs < 2q.
- Undefined (default): full reduction, latency K+1, out_data < q.

Decomposition:
- Package wlmr_pkg:
  - function clog_div(a,b) for K = ceil(LOGQ/WORD_SIZE);
  - localparam-computing helpers for stage width (2*LOGQ+1);
  - typedef of the stage bundle {valid, tag, T}.
- Sub-module wlmr_step: one combinational word-reduction step (t_lo, m, T' equation). It is instantiated K times in a generate loop, with registers and stall/valid control in the parent.

Test Plan:
- Config LOGQ=14, WORD_SIZE=8, qH=0x30 (q=12289), K=2, TAG_W=8.
- Identity: in_data=65536 (2^16), tag=0x11 -> after 3 cycles out_data=1, out_tag=0x11. in_data=196608 -> 3.
- Zero/multiple: in_data=0 -> 0. in_data=12289 -> 0. in_data=131072000 (2000*2^16) -> 2000.
- Back-to-back: 1000 random T < q^2, in_valid=1 every cycle -> outputs in order, one per cycle, each equal to the golden T*2^-16 mod q, tags matching.
- Stall: insert stall=1 for 4 cycles mid-stream -> out_valid/out_data/out_tag frozen, no loss or duplicate; total latency grows by exactly 4.
- Reset mid-stream: assert rst for 1 cycle with 3 operands in flight -> out_valid=0 next cycle and stays 0 until new inputs, +3 cycles.
- WLMR_LAZY_OUT_EN defined: same random stream -> latency 2, out_data ≡ golden mod q and out_data < 24578.
